// File: rtl/sweep_controller.sv
// Frequency sweep sequencer for a DDS: steps a 32-bit tuning word from m_start
// by m_step, strobing set once per point and dwelling a fixed number of cycles.
module sweep_controller #(
  parameter int DWELL_W = 24,
  parameter int STEPS_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               loop,
  input  logic [31:0]        m_start,
  input  logic [31:0]        m_step,
  input  logic [STEPS_W-1:0] n_steps,
  input  logic [DWELL_W-1:0] dwell,
  output logic [31:0]        m,
  output logic               set,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SET   = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        m_q, m_d;
  logic [31:0]        m_start_q, m_start_d;
  logic [31:0]        m_step_q, m_step_d;
  logic [STEPS_W-1:0] n_steps_q, n_steps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic [STEPS_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               set_q, set_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic               dwell_last;

  // A programmed dwell of 0 behaves as a single-cycle dwell.
  assign dwell_eff  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign dwell_last = (dcnt_q == dwell_eff - DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      m_start_q <= '0;
      m_step_q  <= '0;
      n_steps_q <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      step_q    <= '0;
      dcnt_q    <= '0;
      set_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      m_start_q <= m_start_d;
      m_step_q  <= m_step_d;
      n_steps_q <= n_steps_d;
      dwell_q   <= dwell_d;
      loop_q    <= loop_d;
      step_q    <= step_d;
      dcnt_q    <= dcnt_d;
      set_q     <= set_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_SET;
      S_SET:   state_d = S_DWELL;
      S_DWELL: if (dwell_last) state_d = (step_q == n_steps_q) ? S_DONE : S_SET;
      S_DONE:  state_d = loop_q ? S_SET : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition out of a busy state.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    m_d       = m_q;
    m_start_d = m_start_q;
    m_step_d  = m_step_q;
    n_steps_d = n_steps_q;
    dwell_d   = dwell_q;
    loop_d    = loop_q;
    step_d    = step_q;
    dcnt_d    = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_SET) begin
          m_start_d = m_start;
          m_step_d  = m_step;
          n_steps_d = n_steps;
          dwell_d   = dwell;
          loop_d    = loop;
          m_d       = m_start;
          step_d    = '0;
          dcnt_d    = '0;
        end
      end
      S_SET: dcnt_d = '0;
      S_DWELL: begin
        if (state_d == S_DWELL) begin
          dcnt_d = dcnt_q + DWELL_W'(1);
        end else if (state_d == S_SET) begin
          m_d    = m_q + m_step_q;
          step_d = step_q + STEPS_W'(1);
          dcnt_d = '0;
        end
      end
      S_DONE: begin
        if (state_d == S_SET) begin
          m_d    = m_start_q;
          step_d = '0;
          dcnt_d = '0;
        end
      end
      default: ;
    endcase
    set_d  = (state_d == S_SET);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign m         = m_q;
  assign set       = set_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Self-checking bench for sweep_controller: directed and random sweeps compared
// cycle by cycle against a closed-form timing model of the sweep.
module tb_sweep_controller;
  localparam int DW = 24;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, loop;
  logic [31:0]   m_start, m_step;
  logic [SW-1:0] n_steps;
  logic [DW-1:0] dwell;
  logic [31:0]   m;
  logic          set, busy, done;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sweep_controller #(.DWELL_W(DW), .STEPS_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
    .m_start(m_start), .m_step(m_step), .n_steps(n_steps), .dwell(dwell),
    .m(m), .set(set), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // t = cycles since the first SET cycle; each point occupies dwell+1 cycles,
  // followed by one DONE cycle; looping repeats that whole period.
  function automatic void model(input int t, input logic [31:0] ms, input logic [31:0] st,
                                input int n, input int de, input bit lp,
                                output logic e_set, output logic e_done,
                                output logic e_busy, output logic [31:0] e_m);
    int p1  = de + 1;
    int len = (n + 1) * p1 + 1;
    int tt  = lp ? (t % len) : t;
    if (tt >= len) begin
      e_set = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_m = ms + st * 32'(n);
    end else if (tt == (n + 1) * p1) begin
      e_set = 1'b0; e_done = 1'b1; e_busy = 1'b1; e_m = ms + st * 32'(n);
    end else begin
      e_set = ((tt % p1) == 0); e_done = 1'b0; e_busy = 1'b1;
      e_m = ms + st * 32'(tt / p1);
    end
  endfunction

  task automatic scramble();
    m_start = $urandom; m_step = $urandom;
    n_steps = SW'($urandom); dwell = DW'($urandom); loop = 1'($urandom);
  endtask

  task automatic run_sweep(input string name, input logic [31:0] ms, input logic [31:0] st,
                           input int n, input int d, input bit lp,
                           input int abort_t, input int run_len, input bit noise);
    int de = (d == 0) ? 1 : d;
    int len = (n + 1) * (de + 1) + 1;
    logic es, ed, eb;
    logic [31:0] em;
    logic [31:0] m_ab = '0;
    @(negedge clk);
    m_start = ms; m_step = st; n_steps = SW'(n); dwell = DW'(d); loop = lp;
    start = 1'b1; abort = 1'b0;
    for (int t = 0; t < run_len; t++) begin
      @(negedge clk);
      if (abort_t >= 0 && t > abort_t) begin
        es = 1'b0; ed = 1'b0; eb = 1'b0; em = m_ab;
      end else begin
        model(t, ms, st, n, de, lp, es, ed, eb, em);
      end
      if (t == abort_t) m_ab = em;
      check({name, " set"},  32'(set),  32'(es));
      check({name, " done"}, 32'(done), 32'(ed));
      check({name, " busy"}, 32'(busy), 32'(eb));
      check({name, " m"},    m,         em);
      start = noise && (lp || (t + 1 < len)) && (abort_t < 0 || t <= abort_t)
              && ($urandom_range(0, 3) == 0);
      abort = (t == abort_t);
      if (noise) scramble();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    m_start = '0; m_step = '0; n_steps = '0; dwell = '0;
    #12;
    check("reset m", m, 32'h0);
    check("reset set", 32'(set), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep("basic", 32'd1000, 32'd10, 3, 4, 1'b0, -1, 23, 1'b0);
    run_sweep("wrap", 32'hFFFF_FFF0, 32'h10, 1, 0, 1'b0, -1, 7, 1'b0);
    run_sweep("loop", 32'h1234_5678, 32'h100, 2, 3, 1'b1, 44, 50, 1'b0);
    run_sweep("abort2", 32'd500, 32'd7, 3, 4, 1'b0, 7, 15, 1'b0);
    run_sweep("down", 32'd100, 32'hFFFF_FFFB, 4, 2, 1'b0, -1, 18, 1'b0);
    run_sweep("single", 32'hCAFE_0000, 32'd1, 0, 3, 1'b0, -1, 7, 1'b0);

    // start and abort together while idle must not launch a sweep
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("idle_sa busy", 32'(busy), 32'h0);
      check("idle_sa set", 32'(set), 32'h0);
    end

    run_sweep("restart", 32'd42, 32'd3, 3, 2, 1'b0, -1, 15, 1'b1);

    // asynchronous reset in the middle of a dwell
    @(negedge clk);
    m_start = 32'hABCD; m_step = 32'h1; n_steps = SW'(3); dwell = DW'(5); loop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst m", m, 32'h0);
    check("async_rst set", 32'(set), 32'h0);
    check("async_rst busy", 32'(busy), 32'h0);
    check("async_rst done", 32'(done), 32'h0);
    check("async_rst state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst set", 32'(set), 32'h0);
      check("post_rst busy", 32'(busy), 32'h0);
    end

    for (int i = 0; i < 15; i++) begin
      int n = $urandom_range(0, 5);
      int d = $urandom_range(0, 6);
      bit lp = 1'($urandom);
      int de = (d == 0) ? 1 : d;
      int len = (n + 1) * (de + 1) + 1;
      int ab, rl;
      if (lp) begin
        ab = $urandom_range(0, 2 * len);
        rl = ab + 3;
      end else begin
        ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
        rl = len + 2;
      end
      run_sweep("rand", $urandom, $urandom, n, d, lp, ab, rl, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
